// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive path.
// UART_RX_MAJORITY_EN selects 2-of-3 majority sampling in the framer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int DEF_CLOCK_FREQ = 125_000_000;
    localparam int DEF_BAUD_RATE  = 115_200;
    localparam int SYNC_STAGES    = 2;

    function automatic int symbol_edge_time(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int sample_time(input int set);
        return set / 2;
    endfunction

    function automatic int cnt_width(input int set);
        return (set > 1) ? $clog2(set) : 1;
    endfunction

    localparam int CNT_W =
        cnt_width(symbol_edge_time(DEF_CLOCK_FREQ, DEF_BAUD_RATE));

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for idle-high serial lines.
// Flops reset to 1 so an idle line never looks like a start bit.
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= '1;
        end else begin
            r_ff <= {r_ff[N-2:0], i_d};
        end
    end

    assign o_q = r_ff[N-1];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start/data/stop framing into a one-deep holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int ST  = sample_time(SET);
    localparam int CW  = cnt_width(SET);

`ifdef UART_RX_MAJORITY_EN
    // The window register lags rx_s by one cycle, so the start decision
    // lands two cycles later to keep the window centred on the bit.
    localparam int START_HIT = ST + 1;
`else
    localparam int START_HIT = ST - 1;
`endif

    localparam logic [CW-1:0] START_LAST = CW'(START_HIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(SET - 1);

    generate
        if (SET < 4) begin : g_bad_baud
            $error("uart_rx_framer: CLOCK_FREQ/BAUD_RATE must be >= 4");
        end
    endgenerate

    uart_rx_state_t r_state;
    uart_rx_state_t w_next;

    logic          w_rx_s;
    logic          w_bit;
    logic          w_hit;
    logic          w_shift;
    logic          w_commit;
    logic          w_ferr;
    logic          w_pop;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    uart_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (serial_in),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] r_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= 3'b111;
        end else begin
            r_win <= {r_win[1:0], w_rx_s};
        end
    end

    assign w_bit = (r_win[0] & r_win[1]) |
                   (r_win[0] & r_win[2]) |
                   (r_win[1] & r_win[2]);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) w_next = START;
            end
            START: begin
                if (w_hit) w_next = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_hit && (r_bit_cnt == 3'd7)) w_next = STOP;
            end
            STOP: begin
                if (w_hit) w_next = w_bit ? IDLE : BREAK;
            end
            BREAK: begin
                if (w_rx_s) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_hit    = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_ferr   = 1'b0;
        unique case (r_state)
            START: begin
                w_hit = (r_cnt == START_LAST);
            end
            DATA: begin
                w_hit   = (r_cnt == BIT_LAST);
                w_shift = w_hit;
            end
            STOP: begin
                w_hit    = (r_cnt == BIT_LAST);
                w_commit = w_hit & w_bit;
                w_ferr   = w_hit & ~w_bit;
            end
            default: ;
        endcase
    end

    assign w_pop = r_valid & data_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == START) || (r_state == DATA) || (r_state == STOP)) begin
                r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end
        end
    end

    // A same-cycle pop frees the slot, so a commit never overruns then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_commit & r_valid & ~w_pop;
            if (w_commit && (!r_valid || w_pop)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign framing_error  = r_ferr;
    assign overrun        = r_ovr;
    assign rx_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 5 clocks per bit.
// Honours UART_RX_MAJORITY_EN for the glitch-tolerance step.
module tb_uart_rx_framer;

    localparam int SET = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
    logic       framing_error;
    logic       overrun;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pops[$];
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_vcyc  = 0;
    int n_busy  = 0;

    uart_rx_framer #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (10_000_000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) pops.push_back(data_out);
        if (framing_error) n_ferr++;
        if (overrun) n_ovr++;
        if (data_out_valid) n_vcyc++;
        if (rx_busy) n_busy++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pop_at(input int idx);
        if (idx < pops.size()) return pops[idx];
        return 8'hxx;
    endfunction

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (SET) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic send_glitch_byte(input logic [7:0] b, input int gbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                serial_in = b[i];
                repeat (2) @(posedge clk);
                #1;
                serial_in = ~b[i];
                @(posedge clk);
                #1;
                serial_in = b[i];
                repeat (2) @(posedge clk);
                #1;
            end else begin
                drive_bit(b[i]);
            end
        end
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        int p0;
        int f0;
        int o0;
        int v0;
        int b0;

        @(negedge clk);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_ferr", framing_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // single byte 0x78
        p0 = pops.size(); f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_busy", rx_busy, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive_bit(i < 3 ? 1'b0 : (i < 7 ? 1'b1 : 1'b0));
        drive_bit(1'b1);
        idle(10);
        check("t1_npop", pops.size() - p0, 1);
        check("t1_data", pop_at(p0), 8'h78);
        check("t1_vcyc", n_vcyc - v0, 1);
        check("t1_ferr", n_ferr - f0, 0);
        check("t1_ovr", n_ovr - o0, 0);

        // back-to-back frames
        p0 = pops.size(); o0 = n_ovr; f0 = n_ferr;
        send_byte(8'h78, 1'b1);
        send_byte(8'h79, 1'b1);
        send_byte(8'h7a, 1'b1);
        send_byte(8'h0d, 1'b1);
        idle(10);
        check("t2_npop", pops.size() - p0, 4);
        check("t2_b0", pop_at(p0), 8'h78);
        check("t2_b1", pop_at(p0 + 1), 8'h79);
        check("t2_b2", pop_at(p0 + 2), 8'h7a);
        check("t2_b3", pop_at(p0 + 3), 8'h0d);
        check("t2_ovr", n_ovr - o0, 0);
        check("t2_ferr", n_ferr - f0, 0);

        // overrun while holding register full
        data_out_ready = 1'b0;
        p0 = pops.size(); o0 = n_ovr;
        send_byte(8'h31, 1'b1);
        send_byte(8'h35, 1'b1);
        idle(10);
        check("t3_hold", data_out, 8'h31);
        check("t3_valid", data_out_valid, 1'b1);
        check("t3_ovr", n_ovr - o0, 1);
        check("t3_nopop", pops.size() - p0, 0);
        data_out_ready = 1'b1;
        idle(3);
        check("t3_npop", pops.size() - p0, 1);
        check("t3_pop", pop_at(p0), 8'h31);
        check("t3_empty", data_out_valid, 1'b0);

        // framing error then recovery
        p0 = pops.size(); f0 = n_ferr; o0 = n_ovr;
        send_byte(8'h3e, 1'b0);
        idle(2 * SET);
        send_byte(8'h20, 1'b1);
        idle(10);
        check("t4_ferr", n_ferr - f0, 1);
        check("t4_npop", pops.size() - p0, 1);
        check("t4_data", pop_at(p0), 8'h20);
        check("t4_ovr", n_ovr - o0, 0);

        // one-cycle glitch on idle line
        p0 = pops.size(); f0 = n_ferr; o0 = n_ovr; b0 = n_busy;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        idle(12);
`ifdef UART_RX_MAJORITY_EN
        check("t5_busy", n_busy - b0, 4);
`else
        check("t5_busy", n_busy - b0, 2);
`endif
        check("t5_idle", rx_busy, 1'b0);
        check("t5_npop", pops.size() - p0, 0);
        check("t5_ferr", n_ferr - f0, 0);
        check("t5_ovr", n_ovr - o0, 0);

`ifdef UART_RX_MAJORITY_EN
        p0 = pops.size();
        send_glitch_byte(8'h55, 2);
        idle(10);
        check("t5m_npop", pops.size() - p0, 1);
        check("t5m_data", pop_at(p0), 8'h55);
`endif

        // reset mid-frame
        p0 = pops.size(); f0 = n_ferr;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        serial_in = 1'b1;
        @(negedge clk);
        check("t6_rdata", data_out, 8'h00);
        check("t6_rvalid", data_out_valid, 1'b0);
        check("t6_rbusy", rx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        send_byte(8'h5a, 1'b1);
        idle(10);
        check("t6_npop", pops.size() - p0, 1);
        check("t6_data", pop_at(p0), 8'h5a);
        check("t6_ferr", n_ferr - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- On-chip UART receiver front end. Converts the `serial_in` line driven by the host into bytes for the CPU's memory-mapped UART RX data/status registers.
- Sits directly downstream of the host-side serial line and upstream of the CPU MMIO read path.
- Provides a one-deep output holding register with a valid/ready handshake, plus framing-error and overrun reporting.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- Derived constant SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE: cycles per bit. Must be ≥ 4; elaboration error otherwise.
- Derived constant SAMPLE_TIME = SYMBOL_EDGE_TIME/2: mid-bit offset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; all flops clear on assertion.
- serial_in  in  1  asynchronous RX line; idle high.
- data_out  out  8  received byte; valid only when data_out_valid=1.
- data_out_valid  out  1  holding register full.
- data_out_ready  in  1  consumer pops on data_out_valid & data_out_ready.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- rx_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values:
  - data_out=0, data_out_valid=0, framing_error=0, overrun=0, rx_busy=0.
  - Synchronizer flops=1; state=IDLE; bit counter=0; cycle counter=0.
- Synchronizer: serial_in passes through 2 flops (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- FSM:
  - IDLE: rx_s==0 → START; cycle counter cleared.
  - START:
    - Counter runs to SAMPLE_TIME-1, then the line is sampled.
    - Sample=1 → IDLE (glitch rejected, nothing reported).
    - Sample=0 → DATA, counter cleared.
  - DATA:
    - Each time the counter reaches SYMBOL_EDGE_TIME-1, sample the bit and clear the counter.
    - Shift register loads LSB first: shift right, new bit into bit 7.
    - After the 8th sample → STOP.
  - STOP: at counter SYMBOL_EDGE_TIME-1, sample.
    - Sample=1 → commit (see below), → IDLE.
    - Sample=0 → framing_error pulses next cycle, byte discarded, → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. No new start bit is detected while the line stays low.
- Commit rules (registered; valid rises the cycle after the stop-bit sample):
  - Holding register empty, or popped in the same cycle → load data_out, data_out_valid=1.
  - Otherwise → overrun pulses one cycle. The held byte is kept unchanged; the new byte is dropped.
- Pop: data_out_valid & data_out_ready with no simultaneous commit → data_out_valid=0 next cycle. data_out holds its last value.
- data_out is stable while data_out_valid=1 and not popped.
- Back-to-back frames: a start bit immediately after the stop bit (no idle gap) must be detected. IDLE re-checks rx_s on the cycle after STOP.
- Frame timing: the stop sample occurs SAMPLE_TIME + 9·SYMBOL_EDGE_TIME cycles after entering START.
- rst_n asserted mid-frame: the partial byte is lost and the held byte is cleared. After release the block starts in IDLE and needs a fresh falling edge to begin a frame.

Optional Feature:
- UART_RX_MAJORITY_EN defined:
  - Every sample point (start, data, stop) takes the 2-of-3 majority of rx_s at offsets −1, 0, +1 cycles around the nominal point. The decision is made at the +1 offset.
  - All subsequent sample points shift by 0; the frame period is unchanged.
  - Adds a 3-bit sample window register.
- Undefined: single sample of rx_s at the nominal point.

Decomposition:
- Package uart_pkg:
  - State enum uart_rx_state_t: IDLE, START, DATA, STOP, BREAK.
  - Function computing SYMBOL_EDGE_TIME/SAMPLE_TIME.
  - Localparam for counter width: $clog2(SYMBOL_EDGE_TIME).
- Sub-module uart_sync: parameterised N-flop synchronizer, reset value 1, async active-low reset. Reusable by the TX loopback path.

Test Plan (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000, so 5 cycles/bit):
- Reset then idle line: send 8'h78 with data_out_ready=1 → data_out_valid one cycle, data_out=8'h78, no error pulses.
- Send 'x','y','z',8'h0d back-to-back with no idle gap, ready held high → four pops in order 78,79,7a,0d; no overrun.
- Hold data_out_ready=0, send 8'h31 then 8'h35 → data_out stays 8'h31, overrun pulses once, then ready=1 pops 8'h31 only.
- Send a frame 8'h3e with the stop bit forced 0, then the line high for 2 bits, then 8'h20 → framing_error one pulse, no valid for 3e, 8'h20 received.
- Glitch: serial_in low for 1 cycle → state returns to IDLE, no valid, no errors. With UART_RX_MAJORITY_EN, a single-cycle inverted glitch mid data bit on 8'h55 → 8'h55 still received.
- Assert rst_n for 3 cycles mid-DATA of 8'hA5, then send 8'h5A → only 8'h5A appears, outputs reset during rst_n.
